// File: rtl/winograd_pkg.sv
// Shared types and constants for the stride-2 Winograd convolution path.
// Also hosts the index-width helper used for counter and port sizing.
package winograd_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ROWS  = 224;
    localparam int DEF_COLS  = 224;

    typedef logic signed [DEF_WIDTH-1:0] pixel_t;

    typedef struct packed {
        pixel_t ee;
        pixel_t eo;
        pixel_t oe;
        pixel_t oo;
    } quad_t;

    typedef enum logic [1:0] {
        EVEN_ROW     = 2'd0,
        ODD_EVEN_COL = 2'd1,
        ODD_ODD_COL  = 2'd2
    } split_state_e;

    // Never returns zero, so a dimension of 1 still yields a legal vector.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/polyphase_line_buf.sv
// Even/odd column line buffer holding one even row of the frame.
// One shared write port, combinational read of both banks at one address.
module polyphase_line_buf
    import winograd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_COLS / 2,
    parameter int AW    = idx_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_odd,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_e,
    output logic [WIDTH-1:0] rd_o
);

    logic [WIDTH-1:0] bank_e [DEPTH];
    logic [WIDTH-1:0] bank_o [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_odd) bank_o[wr_addr] <= wr_data;
            else        bank_e[wr_addr] <= wr_data;
        end
    end

    assign rd_e = bank_e[rd_addr];
    assign rd_o = bank_o[rd_addr];

endmodule

// File: rtl/polyphase_split.sv
// Raster-order pixel stream to co-located polyphase quads.
// Even rows are buffered; each odd-odd pixel completes and emits one quad.
module polyphase_split
    import winograd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int RQ    = idx_bits(ROWS / 2),
    parameter int CQ    = idx_bits(COLS / 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ee,
    output logic [WIDTH-1:0] out_eo,
    output logic [WIDTH-1:0] out_oe,
    output logic [WIDTH-1:0] out_oo,
    output logic [RQ-1:0]    out_row,
    output logic [CQ-1:0]    out_col,
    output logic             divide_done
);

    localparam int RW = idx_bits(ROWS);
    localparam int CW = idx_bits(COLS);

    split_state_e     state;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic [WIDTH-1:0] oe_hold;
    logic [WIDTH-1:0] rd_e;
    logic [WIDTH-1:0] rd_o;
    logic [CQ-1:0]    col_half;
    logic             in_hs;
    logic             out_hs;
    logic             last_col;
    logic             last_row;
    logic             load;
    logic             buf_we;

    // Only the quad-completing pixel has to wait for the output slot.
    assign in_ready = rst_n &&
        ((state != ODD_ODD_COL) || !out_valid || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));
    assign col_half = CQ'(col >> 1);
    assign load     = in_hs && (state == ODD_ODD_COL);
    assign buf_we   = in_hs && (state == EVEN_ROW);

    polyphase_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (COLS / 2),
        .AW    (CQ)
    ) u_line_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_odd  (col[0]),
        .wr_addr (col_half),
        .wr_data (in_data),
        .rd_addr (col_half),
        .rd_e    (rd_e),
        .rd_o    (rd_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (in_hs) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EVEN_ROW;
        end else if (in_hs) begin
            unique case (1'b1)
                state == EVEN_ROW:
                    if (last_col) state <= ODD_EVEN_COL;
                state == ODD_EVEN_COL:
                    state <= ODD_ODD_COL;
                state == ODD_ODD_COL:
                    state <= last_col ? EVEN_ROW : ODD_EVEN_COL;
                default:
                    state <= EVEN_ROW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oe_hold <= '0;
        end else if (in_hs && state == ODD_EVEN_COL) begin
            oe_hold <= in_data;
        end
    end

    // Output slot holds copies, so the line buffer may be reused freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_ee      <= '0;
            out_eo      <= '0;
            out_oe      <= '0;
            out_oo      <= '0;
            out_row     <= '0;
            out_col     <= '0;
            divide_done <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_ee    <= rd_e;
                out_eo    <= rd_o;
                out_oe    <= oe_hold;
                out_oo    <= in_data;
                out_row   <= RQ'(row >> 1);
                out_col   <= col_half;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            divide_done <= out_hs &&
                (out_row == RQ'(ROWS / 2 - 1)) &&
                (out_col == CQ'(COLS / 2 - 1));
        end
    end

endmodule
